// File: rtl/serial_subtractor.sv
// Bit-serial N-bit subtractor: computes a - b - bin one bit per clock, LSB first,
// with valid/ready handshakes on both the operand and the result side.
module serial_subtractor #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         bin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] diff,
    output logic         bout,
    output logic         ovf,
    output logic         zero
);

    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         state, state_nx;
    logic [N-1:0]   a_sh, b_sh, diff_sh;
    logic           borrow;
    logic [CW-1:0]  cnt;
    logic           a_msb, b_msb;

    logic           x, y, d, borrow_nx, last;
    logic [N-1:0]   diff_nx;

    assign x         = a_sh[0];
    assign y         = b_sh[0];
    assign d         = x ^ y ^ borrow;
    assign borrow_nx = (~x & y) | (~(x ^ y) & borrow);
    assign last      = (cnt == CW'(N - 1));

    // New difference bit enters at the MSB; written this way so N = 1 needs no special case.
    always_comb begin
        diff_nx        = diff_sh >> 1;
        diff_nx[N-1]   = d;
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (in_valid)  state_nx = RUN;
            RUN:     if (last)      state_nx = DONE;
            DONE:    if (out_ready) state_nx = IDLE;
            default:                state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh    <= '0;
            b_sh    <= '0;
            diff_sh <= '0;
            borrow  <= 1'b0;
            cnt     <= '0;
            a_msb   <= 1'b0;
            b_msb   <= 1'b0;
            diff    <= '0;
            bout    <= 1'b0;
            ovf     <= 1'b0;
            zero    <= 1'b0;
        end else if (state == IDLE && in_valid) begin
            a_sh    <= a;
            b_sh    <= b;
            borrow  <= bin;
            cnt     <= '0;
            a_msb   <= a[N-1];
            b_msb   <= b[N-1];
        end else if (state == RUN) begin
            a_sh    <= a_sh >> 1;
            b_sh    <= b_sh >> 1;
            diff_sh <= diff_nx;
            borrow  <= borrow_nx;
            cnt     <= cnt + CW'(1);
            // Results are published on the final bit so DONE sees them immediately.
            if (last) begin
                diff <= diff_nx;
                bout <= borrow_nx;
                ovf  <= (a_msb != b_msb) && (diff_nx[N-1] != a_msb);
                zero <= (diff_nx == '0);
            end
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and randomized-stream bench for serial_subtractor (N = 8).
module tb_serial_subtractor;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [N-1:0] a = '0;
    logic [N-1:0] b = '0;
    logic         bin = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [N-1:0] diff;
    logic         bout, ovf, zero;

    int checks = 0;
    int failures = 0;

    serial_subtractor #(.N(N)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .bin(bin), .out_valid(out_valid), .out_ready(out_ready),
        .diff(diff), .bout(bout), .ovf(ovf), .zero(zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Present operands, let them be accepted, and return cycles until out_valid.
    task automatic start_op(input logic [7:0] av, input logic [7:0] bv, input logic bi,
                            output int lat);
        a = av; b = bv; bin = bi; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic check_res(input string tag, input logic [7:0] ed, input logic eb,
                             input logic eo, input logic ez);
        check({tag, "_valid"}, out_valid, 1'b1);
        check({tag, "_diff"}, diff, ed);
        check({tag, "_bout"}, bout, eb);
        check({tag, "_ovf"},  ovf,  eo);
        check({tag, "_zero"}, zero, ez);
    endtask

    task automatic release_res(input string tag);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, "_rdy_after"}, in_ready, 1'b1);
        check({tag, "_ov_after"}, out_valid, 1'b0);
    endtask

    int lat;
    logic [7:0] hold_diff;
    logic [7:0] q_d[$];
    logic       q_b[$], q_o[$], q_z[$];
    int received;
    bit stream_done;

    initial begin
        // Reset state
        #2;
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_diff", diff, 8'h00);
        check("rst_flags", {bout, ovf, zero}, 3'b000);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        start_op(8'd100, 8'd58, 1'b0, lat);
        check("basic_latency", lat, N);
        check_res("basic", 8'h2A, 1'b0, 1'b0, 1'b0);
        release_res("basic");

        start_op(8'h00, 8'h01, 1'b0, lat);
        check_res("underflow", 8'hFF, 1'b1, 1'b0, 1'b0);
        release_res("underflow");

        start_op(8'h80, 8'h01, 1'b0, lat);
        check_res("sovf", 8'h7F, 1'b0, 1'b1, 1'b0);
        release_res("sovf");

        start_op(8'h55, 8'h54, 1'b1, lat);
        check_res("zero_bin", 8'h00, 1'b0, 1'b0, 1'b1);
        release_res("zero_bin");

        // Backpressure: DONE held while new operands are offered
        start_op(8'h37, 8'h12, 1'b0, lat);
        check_res("bp_first", 8'h25, 1'b0, 1'b0, 1'b0);
        hold_diff = diff;
        a = 8'h33; b = 8'h11; bin = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp_diff_stable", diff, hold_diff);
            check("bp_flags_stable", {bout, ovf, zero}, 3'b000);
            check("bp_in_ready", in_ready, 1'b0);
            check("bp_out_valid", out_valid, 1'b1);
        end
        in_valid = 1'b0;
        release_res("bp");
        @(posedge clk); #1;
        check("bp_no_capture", in_ready, 1'b1);

        // Reset in the middle of RUN (previous result 0x25 is still on diff)
        a = 8'hC3; b = 8'h5A; bin = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("mid_prereset_diff", diff, 8'h25);
        rst_n = 1'b0;
        #1;
        check("mid_rst_in_ready", in_ready, 1'b1);
        check("mid_rst_out_valid", out_valid, 1'b0);
        check("mid_rst_diff", diff, 8'h00);
        check("mid_rst_flags", {bout, ovf, zero}, 3'b000);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        start_op(8'h10, 8'h20, 1'b0, lat);
        check("after_rst_latency", lat, N);
        check_res("after_rst", 8'hF0, 1'b1, 1'b0, 1'b0);
        release_res("after_rst");

        // Random stream with gaps on both sides
        received = 0;
        stream_done = 0;
        fork
            begin : producer
                for (int i = 0; i < 1000; i++) begin
                    logic [7:0] av, bv, dv;
                    logic       bi;
                    logic [8:0] sub;
                    int w;
                    av = 8'($urandom); bv = 8'($urandom); bi = 1'($urandom);
                    repeat ($urandom_range(0, 3)) begin
                        @(posedge clk); #1;
                    end
                    a = av; b = bv; bin = bi; in_valid = 1'b1;
                    w = 0;
                    while (!in_ready && w < 200) begin
                        @(posedge clk); #1;
                        w++;
                    end
                    if (w >= 200) check("stream_accept_timeout", 1, 0);
                    sub = {1'b0, av} - {1'b0, bv} - {8'b0, bi};
                    dv  = sub[7:0];
                    q_d.push_back(dv);
                    q_b.push_back({1'b0, av} < ({1'b0, bv} + {8'b0, bi}));
                    q_o.push_back((av[7] != bv[7]) && (dv[7] != av[7]));
                    q_z.push_back(dv == 8'h00);
                    @(posedge clk); #1;
                    in_valid = 1'b0;
                    a = 8'($urandom); b = 8'($urandom);
                end
            end
            begin : consumer
                int cyc;
                cyc = 0;
                while (received < 1000 && cyc < 60000) begin
                    out_ready = 1'($urandom_range(0, 2) != 0);
                    if (out_valid && out_ready) begin
                        if (q_d.size() == 0) begin
                            check("stream_unexpected_result", 1, 0);
                        end else begin
                            check("stream_diff", diff, q_d.pop_front());
                            check("stream_bout", bout, q_b.pop_front());
                            check("stream_ovf",  ovf,  q_o.pop_front());
                            check("stream_zero", zero, q_z.pop_front());
                        end
                        received++;
                    end
                    @(posedge clk); #1;
                    cyc++;
                end
                out_ready = 1'b0;
            end
        join
        check("stream_count", received, 1000);
        check("stream_leftover", q_d.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial N-bit subtractor with borrow-in, computing `a - b - bin` one bit per clock, LSB first, through a single registered borrow stage. It is the subtraction counterpart of the team's N-bit ripple-carry adder. It trades latency for area: one difference/borrow cell is reused across N cycles instead of N chained cells. Operands arrive and results leave on independent valid/ready handshakes, so it drops into streaming datapaths.

## Interface
- `N`, default 8: operand and result width. Legal for N ≥ 1. The bit counter is `$clog2(N+1)` bits wide.
- `clk`  input  1  : single clock; all state updates on the rising edge.
- `rst_n`  input  1  : reset, asynchronous, active-low.
- `in_valid`  input  1  : operands `a`, `b`, `bin` are valid.
- `in_ready`  output  1  : block can accept operands; high only in IDLE.
- `a`  input  N  : minuend.
- `b`  input  N  : subtrahend.
- `bin`  input  1  : borrow-in.
- `out_valid`  output  1  : result fields are valid; high only in DONE.
- `out_ready`  input  1  : consumer accepts the result.
- `diff`  output  N  : `(a - b - bin) mod 2^N`.
- `bout`  output  1  : unsigned borrow-out; 1 iff `a < b + bin`.
- `ovf`  output  1  : two's-complement overflow of the signed subtraction.
- `zero`  output  1  : 1 iff `diff == 0`.

## Operation
- The block has three states: IDLE, RUN and DONE.
- **IDLE:**
  - `in_ready` = 1.
  - On `in_valid && in_ready`: capture `a`, `b` into shift registers, load the borrow register with `bin`, clear the counter, and go to RUN.
- **RUN:**
  - Each cycle, with `x = a_sh[0]`, `y = b_sh[0]`, `c = borrow`:
    - `d = x ^ y ^ c`
    - `borrow <= (~x & y) | (~(x ^ y) & c)`
  - `d` shifts into the MSB of `diff_sh`; `a_sh` and `b_sh` shift right; the counter increments.
  - When the counter reaches N-1 (the last bit is processed this cycle), go to DONE.
  - In the same edge, register the results:
    - `diff`
    - `bout` = final borrow
    - `ovf` = `(a_msb != b_msb) && (diff_msb != a_msb)`, where `a_msb` and `b_msb` are the captured operand MSBs
    - `zero` = `(diff == 0)`
- **DONE:**
  - `out_valid` = 1.
  - `diff`, `bout`, `ovf` and `zero` are held stable.
  - On `out_valid && out_ready`, return to IDLE.
- `in_ready` and `out_valid` decode directly from state. They are never high together.
- Operands presented outside IDLE are ignored. The input bus need not stay stable after the accept edge.
- N = 1 is legal: RUN lasts exactly one cycle.

## Timing
- **Reset values:**
  - State = IDLE, so `in_ready` = 1 during and after reset.
  - `out_valid` = 0.
  - `diff` = 0, `bout` = 0, `ovf` = 0, `zero` = 0.
  - Internal shift registers, borrow and counter = 0.
- **Latency:** with the accept edge at E, `out_valid` rises after edge E+N. RUN lasts exactly N cycles.
- **Result hand-off:** the result is taken on the first edge with `out_valid && out_ready`. `in_ready` rises in the following cycle. There is no same-cycle result-out/operand-in overlap.
- **Throughput:** at best one operation per N+2 cycles (accept cycle, N RUN cycles, one DONE cycle).
- **Backpressure:** DONE holds indefinitely while `out_ready` = 0. Outputs do not change, and `in_valid` is ignored.
- **Reset mid-operation:** asserting `rst_n` low in RUN or DONE aborts immediately. All outputs go to their reset values, no result is emitted, and the next accepted operation is unaffected.
- **Wrap-around:** results are modulo 2^N. A borrow is reported only through `bout`, never by widening `diff`.

## Test plan
- **Basic subtract (N=8):** `a`=100, `b`=58, `bin`=0 → `diff`=0x2A, `bout`=0, `ovf`=0, `zero`=0. `out_valid` rises exactly 8 cycles after the accept edge.
- **Unsigned underflow:** `a`=0x00, `b`=0x01, `bin`=0 → `diff`=0xFF, `bout`=1, `ovf`=0, `zero`=0.
- **Signed overflow with borrow-in:**
  - `a`=0x80, `b`=0x01, `bin`=0 → `diff`=0x7F, `bout`=0, `ovf`=1.
  - `a`=0x55, `b`=0x54, `bin`=1 → `diff`=0x00, `zero`=1, `bout`=0.
- **Backpressure:**
  - Hold `out_ready`=0 for 5 cycles in DONE while driving `in_valid`=1 with new operands.
  - Required: `diff` and flags stable, `in_ready`=0, new operands not captured.
  - After `out_ready` pulses, `in_ready`=1 on the next cycle.
- **Reset mid-RUN:**
  - Pull `rst_n` low 3 cycles after accept.
  - Required: all outputs at reset values asynchronously and `in_ready`=1.
  - A following `a`=0x10, `b`=0x20 yields `diff`=0xF0, `bout`=1.
- **Back-to-back stream:**
  - 1000 random `a`/`b`/`bin` with random `in_valid`/`out_ready` gaps.
  - Required: every result matches the reference model `(a - b - bin) mod 256` plus flags, in order, none lost or duplicated.
